multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle main controller for the MIPS32 core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback using the shared ALU, memory port and register file. It decodes opcode/funct to drive the ALU control code and every datapath enable. It owns the single memory port's request/ready handshake, so fetch and data accesses stall cleanly on slow memory.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  current instruction from the datapath instruction register (IR).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid; held until mem_ready.
- mem_we  out  1  request is a write (store).
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_ctrl  out  3  ALU operation code.
- reg_we  out  1  register file write.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = memory data register.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct.

## Operation
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
- Supported opcodes:
  - R-type 000000, funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, addi 001000, slti 001010.
  - j 000010.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00. ir_we and pc_we equal mem_ready. Moves to DECODE on mem_ready, otherwise stays.
  - DECODE: alu_src_a=0, alu_src_b=11, add; computes the branch target into ALUOut.
    - lw/sw go to MEMADR; R-type goes to RTEXEC; addi/slti go to IEXEC; beq goes to BRANCH; j goes to JUMP.
    - Any other opcode or R-type funct: illegal=1, instr_done=1, next state FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, add. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD: mem_req=1, iord=1. On mem_ready goes to MEMWB.
  - MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1. Goes to FETCH.
  - MEMWR: mem_req=1, mem_we=1, iord=1. On mem_ready: instr_done=1, goes to FETCH.
  - RTEXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. Goes to RTWB.
  - RTWB: reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
  - IEXEC: alu_src_a=1, alu_src_b=10, alu_ctrl=add for addi, slt for slti. Goes to IWB.
  - IWB: reg_we=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_we=zero, instr_done=1. Goes to FETCH.
  - JUMP: pc_src=10, pc_we=1, instr_done=1. Goes to FETCH.
- Any output not listed for a state is 0.
- instr is sampled only in DECODE and later states; it is stable there because ir_we is low.

## Timing
- State register updates on the rising edge of clk. All outputs are decoded from the state.
- Exceptions to pure state decode:
  - FETCH ir_we/pc_we are qualified by mem_ready.
  - BRANCH pc_we is qualified by zero.
  - MEMWR instr_done is qualified by mem_ready.
  - alu_ctrl depends on instr funct/opcode in RTEXEC and IEXEC.
- Handshake: mem_req, mem_we and iord stay constant from request assertion through the cycle mem_ready=1. mem_ready while mem_req=0 is ignored.
- Cycles per instruction with mem_ready tied high: beq 3, j 3, R-type 4, addi/slti 4, sw 4, lw 5, illegal 2. Each wait cycle on a memory access adds 1.
- Reset: rst_n low forces FETCH immediately, independent of clk, and every output to 0; mem_req may drop mid-request. After release, the first rising edge starts FETCH with mem_req=1.

## Configuration
- MCCTRL_JUMP_EN defined: opcode 000010 is decoded and uses the JUMP state.
- MCCTRL_JUMP_EN undefined: the JUMP state is not built. Opcode 000010 is illegal (illegal pulse, return to FETCH) and pc_src never drives 10.

## Test plan
- add (opcode 0, funct 100000), mem_ready=1 -> states FETCH, DECODE, RTEXEC, RTWB. alu_ctrl=010 in RTEXEC; reg_we=1, reg_dst=1 in cycle 4; instr_done pulses in cycle 4.
- lw with mem_ready low for 2 cycles in MEMRD -> mem_req=1, iord=1 held for 3 cycles; MEMWB asserts reg_we=1, mem_to_reg=1; 7 cycles total.
- beq with zero=1, then repeated with zero=0 -> BRANCH drives pc_src=01, alu_ctrl=110; pc_we=1 in the first run and 0 in the second; 3 cycles each.
- slti (001010) -> IEXEC alu_ctrl=111; IWB reg_we=1, reg_dst=0.
- Opcode 111111 -> DECODE illegal=1, instr_done=1, next state FETCH. With the macro undefined, opcode 000010 gives the same result; with it defined, pc_we=1 and pc_src=10.
- rst_n pulsed low mid-MEMWR while mem_req=1 -> mem_req drops asynchronously, all outputs 0; after release the controller restarts in FETCH with iord=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS32 main controller: sequences fetch/decode/execute/memory/writeback.
// Optional macro MCCTRL_JUMP_EN builds the JUMP state and decodes opcode 000010.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic        illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef MCCTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef MCCTRL_JUMP_EN
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXEC,
        S_RTWB,
        S_IEXEC,
        S_IWB,
`ifdef MCCTRL_JUMP_EN
        S_JUMP,
`endif
        S_BRANCH
    } state_t;

    state_t state;
    state_t state_next;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       instr_legal;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    // R-type funct decode: ALU operation plus whether the funct is supported.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        instr_legal = 1'b0;
        case (opcode)
            OP_RTYPE:                            instr_legal = funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI,
            OP_SLTI:                             instr_legal = 1'b1;
`ifdef MCCTRL_JUMP_EN
            OP_J:                                instr_legal = 1'b1;
`endif
            default:                             instr_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW:    state_next = S_MEMADR;
                    OP_RTYPE:        state_next = funct_ok ? S_RTEXEC : S_FETCH;
                    OP_ADDI, OP_SLTI: state_next = S_IEXEC;
                    OP_BEQ:          state_next = S_BRANCH;
`ifdef MCCTRL_JUMP_EN
                    OP_J:            state_next = S_JUMP;
`endif
                    default:         state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_RTEXEC: state_next = S_RTWB;
            S_IEXEC:  state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Outputs follow the state; reset blanks them immediately so an in-flight request drops.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_ctrl   = ALU_AND;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_ctrl  = ALU_ADD;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMMSH2;
                    alu_ctrl   = ALU_ADD;
                    illegal    = ~instr_legal;
                    instr_done = ~instr_legal;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_RTEXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = funct_alu;
                end
                S_RTWB: begin
                    reg_we     = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_IWB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_ctrl   = ALU_SUB;
                    pc_src     = PCSRC_ALUOUT;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end
`ifdef MCCTRL_JUMP_EN
                S_JUMP: begin
                    pc_src     = PCSRC_JUMP;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into an
// expected per-cycle output trace from the instruction-class timing rules.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    localparam int C_RT = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4,
                   C_SLTI = 5, C_J = 6, C_ILL = 7;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic        reg_we, reg_dst, mem_to_reg, instr_done, illegal;

    outs_t got;
    outs_t exp_q[$];
    bit    rdy_q[$];
    bit    zero_q[$];

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_expected = 0;

    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    assign got = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                  alu_ctrl, reg_we, reg_dst, mem_to_reg, instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [2:0] aluForFunct(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic int classify(input logic [31:0] ins);
        logic [5:0] f;
        f = ins[5:0];
        case (ins[31:26])
            6'h00:   return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a) ? C_RT : C_ILL;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h08:   return C_ADDI;
            6'h0a:   return C_SLTI;
`ifdef MCCTRL_JUMP_EN
            6'h02:   return C_J;
`endif
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [5:0] fn);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = op;
        r[5:0] = fn;
        return r;
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input outs_t o, input bit rdy, input bit z);
        exp_q.push_back(o);
        rdy_q.push_back(rdy);
        zero_q.push_back(z);
    endtask

    // Reference model: the cycle-by-cycle output trace an instruction must produce,
    // given fetch wait count wf, data-access wait count wm and branch zero mode (2 = random).
    task automatic buildTrace(input logic [31:0] ins, input int wf, input int wm, input int zmode);
        outs_t o;
        bit z;
        int cls;
        cls = classify(ins);
        for (int k = 0; k <= wf; k++) begin
            o = '0;
            o.mem_req = 1'b1;
            o.alu_src_b = 2'b01;
            o.alu_ctrl = 3'b010;
            o.ir_we = (k == wf);
            o.pc_we = (k == wf);
            push(o, k == wf, rbit());
        end
        o = '0;
        o.alu_src_b = 2'b11;
        o.alu_ctrl = 3'b010;
        if (cls == C_ILL) begin
            o.illegal = 1'b1;
            o.instr_done = 1'b1;
        end
        push(o, rbit(), rbit());
        case (cls)
            C_RT: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_ctrl = aluForFunct(ins[5:0]);
                push(o, rbit(), rbit());
                o = '0; o.reg_we = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
                push(o, rbit(), rbit());
            end
            C_ADDI, C_SLTI: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_ctrl = (cls == C_SLTI) ? 3'b111 : 3'b010;
                push(o, rbit(), rbit());
                o = '0; o.reg_we = 1'b1; o.instr_done = 1'b1;
                push(o, rbit(), rbit());
            end
            C_LW, C_SW: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010;
                push(o, rbit(), rbit());
                for (int k = 0; k <= wm; k++) begin
                    o = '0; o.mem_req = 1'b1; o.iord = 1'b1;
                    o.mem_we = (cls == C_SW);
                    o.instr_done = (cls == C_SW) && (k == wm);
                    push(o, k == wm, rbit());
                end
                if (cls == C_LW) begin
                    o = '0; o.reg_we = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
                    push(o, rbit(), rbit());
                end
            end
            C_BEQ: begin
                z = (zmode == 2) ? rbit() : 1'(zmode);
                o = '0; o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
                o.pc_we = z; o.instr_done = 1'b1;
                push(o, rbit(), z);
            end
            C_J: begin
                o = '0; o.pc_src = 2'b10; o.pc_we = 1'b1; o.instr_done = 1'b1;
                push(o, rbit(), rbit());
            end
            default: ;
        endcase
    endtask

    // Plays the queued trace one cycle at a time; only the first 'limit' cycles are driven.
    task automatic applyStimulus(input logic [31:0] ins, input int limit, input string name);
        outs_t e;
        bit r, z;
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rdy_q.pop_front();
            z = zero_q.pop_front();
            if (n < limit) begin
                @(negedge clk);
                if (n == 0) instr = ins;
                mem_ready = r;
                zero = z;
                #1;
                checkOutput($sformatf("%s_cyc%0d", name, n), 32'(got), 32'(e));
                done_expected += int'(e.instr_done);
                done_seen += int'(instr_done);
            end
            n++;
        end
    endtask

    task automatic runOne(input logic [31:0] ins, input int wf, input int wm, input int zmode, input string name);
        buildTrace(ins, wf, wm, zmode);
        applyStimulus(ins, 1000, name);
    endtask

    initial begin
        outs_t fetch_vec;
        logic [31:0] ins;
        int sel, wf, wm;

        fetch_vec = '0;
        fetch_vec.mem_req = 1'b1;
        fetch_vec.alu_src_b = 2'b01;
        fetch_vec.alu_ctrl = 3'b010;

        rst_n = 1'b0;
        instr = 32'h0;
        zero = 1'b0;
        mem_ready = 1'b0;
        #3;
        checkOutput("rst_init", 32'(got), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_first_fetch", 32'(got), 32'(fetch_vec));

        runOne(mkInstr(6'h00, 6'h20), 0, 0, 2, "add");
        runOne(mkInstr(6'h23, 6'h00), 0, 2, 2, "lw_wait2");
        runOne(mkInstr(6'h04, 6'h00), 0, 0, 1, "beq_z1");
        runOne(mkInstr(6'h04, 6'h00), 0, 0, 0, "beq_z0");
        runOne(mkInstr(6'h0a, 6'h00), 0, 0, 2, "slti");
        runOne(mkInstr(6'h3f, 6'h00), 0, 0, 2, "op3f");
        runOne(mkInstr(6'h02, 6'h00), 0, 0, 2, "j");
        runOne(mkInstr(6'h00, 6'h22), 1, 0, 2, "sub");
        runOne(mkInstr(6'h00, 6'h24), 0, 0, 2, "and");
        runOne(mkInstr(6'h00, 6'h25), 0, 0, 2, "or");
        runOne(mkInstr(6'h00, 6'h2a), 0, 0, 2, "slt");
        runOne(mkInstr(6'h00, 6'h21), 0, 0, 2, "rt_badfn");
        runOne(mkInstr(6'h2b, 6'h00), 2, 1, 2, "sw");
        runOne(mkInstr(6'h08, 6'h00), 0, 0, 2, "addi");

        // Reset asserted mid-store while the request is outstanding.
        ins = mkInstr(6'h2b, 6'h00);
        buildTrace(ins, 0, 3, 2);
        applyStimulus(ins, 4, "sw_pre_rst");
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        checkOutput("rst_async_drop", 32'(got), 32'h0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checkOutput("rst_hold", 32'(got), 32'h0);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        checkOutput("rst_release_fetch", 32'(got), 32'(fetch_vec));

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1, 2, 3, 4: ins = mkInstr(6'h00, fn_tab[$urandom_range(0, 4)]);
                5:       ins = mkInstr(6'h23, 6'h00);
                6:       ins = mkInstr(6'h2b, 6'h00);
                7:       ins = mkInstr(6'h04, 6'h00);
                8:       ins = mkInstr(6'h08, 6'h00);
                9:       ins = mkInstr(6'h0a, 6'h00);
                10:      ins = mkInstr(6'h02, 6'h00);
                default: ins = $urandom;
            endcase
            wf = $urandom_range(0, 5);
            wm = $urandom_range(0, 5);
            if (wf > 3) wf = 0;
            if (wm > 3) wm = 0;
            runOne(ins, wf, wm, 2, $sformatf("rnd%0d", i));
        end

        checkOutput("instr_done_count", 32'(done_seen), 32'(done_expected));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
